// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage posit decoder: specials/negation, then regime/exponent/mantissa unpack
module posit_decode_pipe #(
   parameter int N  = 8,
   parameter int ES = 3,
   parameter int RS = $clog2(N),
   parameter int FW = N - ES - 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_posit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic                 out_zero,
   output logic                 out_nar,
   output logic signed [RS:0]   out_regime,
   output logic [ES-1:0]        out_exp,
   output logic [FW:0]          out_mant
);

   localparam logic [RS:0]  max_run = (RS+1)'(N-1);
   localparam logic [N-1:0] nar_word = {1'b1, {(N-1){1'b0}}};

   logic           s1_valid;
   logic           s1_sign;
   logic           s1_zero;
   logic           s1_nar;
   logic [N-2:0]   s1_rem;
   logic           s1_advance;
   logic [N-1:0]   neg_posit;

   assign s1_advance = s1_valid && (!out_valid || out_ready);
   assign in_ready   = !s1_valid || s1_advance;
   assign neg_posit  = ~in_posit + {{(N-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_rem   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= in_posit[N-1];
            s1_zero <= (in_posit == '0);
            s1_nar  <= (in_posit == nar_word);
            s1_rem  <= in_posit[N-1] ? neg_posit[N-2:0] : in_posit[N-2:0];
         end
      end
   end

   // Regime run length: the leading-bit scan over the magnitude bits.
   logic              run_bit;
   logic              run_done;
   logic [RS:0]       run_len;
   logic [RS:0]       consumed;
   logic [N-2:0]      shifted;
   logic [RS:0]       k_val;
   logic [ES-1:0]     exp_val;
   logic [FW-1:0]     frac_val;

   always_comb begin
      run_bit  = s1_rem[N-2];
      run_done = 1'b0;
      run_len  = '0;
      for (int i = N-2; i >= 0; i--) begin
         if (!run_done && (s1_rem[i] == run_bit))
            run_len = run_len + 1'b1;
         else
            run_done = 1'b1;
      end
      // A run that reaches bit 0 has no terminating bit to skip.
      consumed = (run_len == max_run) ? run_len : run_len + 1'b1;
      shifted  = s1_rem << consumed;
      k_val    = run_bit ? (run_len - 1'b1) : (~run_len + 1'b1);
      exp_val  = shifted[N-2 -: ES];
      frac_val = shifted[N-2-ES -: FW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_sign   <= 1'b0;
         out_zero   <= 1'b0;
         out_nar    <= 1'b0;
         out_regime <= '0;
         out_exp    <= '0;
         out_mant   <= '0;
      end else if (s1_advance) begin
         out_valid <= 1'b1;
         out_sign  <= s1_sign;
         out_zero  <= s1_zero;
         out_nar   <= s1_nar;
         if (s1_zero || s1_nar) begin
            out_regime <= '0;
            out_exp    <= '0;
            out_mant   <= '0;
         end else begin
            out_regime <= $signed(k_val);
            out_exp    <= exp_val;
            out_mant   <= {1'b1, frac_val};
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - randomized and directed bench for posit_decode_pipe with a queue-based posit model
module tb_posit_decode_pipe;

   localparam int N  = 8;
   localparam int ES = 3;
   localparam int RS = $clog2(N);
   localparam int FW = N - ES - 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [N-1:0]        in_posit = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic                out_sign;
   logic                out_zero;
   logic                out_nar;
   logic signed [RS:0]  out_regime;
   logic [ES-1:0]       out_exp;
   logic [FW:0]         out_mant;

   int n_checks = 0;
   int n_pass   = 0;
   int n_out    = 0;
   logic [12:0] exp_q[$];

   posit_decode_pipe #(.N(N), .ES(ES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
      .out_regime(out_regime), .out_exp(out_exp), .out_mant(out_mant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
   endtask

   function automatic logic [12:0] pk(input bit s, input bit z, input bit n,
                                      input int k, input int e, input int m);
      logic [3:0] kb;
      logic [2:0] eb;
      logic [2:0] mb;
      kb = 4'(k);
      eb = 3'(e);
      mb = 3'(m);
      return {s, z, n, kb, eb, mb};
   endfunction

   // Reads the magnitude bits as a sequence: regime run, terminator, exponent, fraction.
   function automatic logic [12:0] model(input logic [7:0] p);
      int bits[$];
      int x, r, run, k, e, f;
      bit s;
      if (p == 8'h00) return pk(0, 1, 0, 0, 0, 0);
      if (p == 8'h80) return pk(1, 0, 1, 0, 0, 0);
      s = p[7];
      x = s ? (256 - int'(p)) : int'(p);
      for (int i = N-2; i >= 0; i--) bits.push_back((x >> i) & 1);
      r = bits[0];
      run = 0;
      while (bits.size() > 0 && bits[0] == r) begin
         void'(bits.pop_front());
         run++;
      end
      k = (r == 1) ? run - 1 : -run;
      if (bits.size() > 0) void'(bits.pop_front());
      e = 0;
      for (int i = 0; i < ES; i++) e = e * 2 + ((bits.size() > 0) ? bits.pop_front() : 0);
      f = 0;
      for (int i = 0; i < FW; i++) f = f * 2 + ((bits.size() > 0) ? bits.pop_front() : 0);
      return pk(s, 0, 0, k, e, (1 << FW) + f);
   endfunction

   function automatic logic [12:0] cur_out();
      return {out_sign, out_zero, out_nar, out_regime, out_exp, out_mant};
   endfunction

   logic [12:0] prev_out;
   bit          prev_stall = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && out_valid) chk("hold", 32'(cur_out()), 32'(prev_out));
         if (in_valid && in_ready) exp_q.push_back(model(in_posit));
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() > 0) chk("out", 32'(cur_out()), 32'(exp_q.pop_front()));
            else chk("spurious_out", 32'(exp_q.size()), 32'd1);
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = cur_out();
      end
   end

   task automatic stream(input int nwords, input int stall_start, input int stall_len,
                         output bit saw_full);
      int idx = 0;
      int cyc = 0;
      bit fired;
      saw_full = 0;
      in_valid = 1'b1;
      in_posit = 8'($urandom);
      while (idx < nwords && cyc < 200) begin
         out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
         @(negedge clk);
         fired = in_ready;
         if (!in_ready) saw_full = 1;
         if (stall_len == 0) chk("b2b_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         if (fired) begin
            idx++;
            in_posit = 8'($urandom);
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_done", 32'(idx), 32'(nwords));
   endtask

   task automatic drain(input string tag);
      int t = 0;
      out_ready = 1'b1;
      while ((exp_q.size() > 0 || out_valid) && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   logic [7:0]  dir_in[8]  = '{8'h40, 8'h5A, 8'h06, 8'h7F, 8'h01, 8'hC0, 8'h00, 8'h80};
   logic [12:0] dir_exp[8];

   initial begin
      bit full;
      int n0;
      dir_exp[0] = pk(0, 0, 0, 0, 3'b000, 3'b100);
      dir_exp[1] = pk(0, 0, 0, 0, 3'b110, 3'b110);
      dir_exp[2] = pk(0, 0, 0, -4, 3'b100, 3'b100);
      dir_exp[3] = pk(0, 0, 0, 6, 3'b000, 3'b100);
      dir_exp[4] = pk(0, 0, 0, -6, 3'b000, 3'b100);
      dir_exp[5] = pk(1, 0, 0, 0, 3'b000, 3'b100);
      dir_exp[6] = pk(0, 1, 0, 0, 0, 0);
      dir_exp[7] = pk(1, 0, 1, 0, 0, 0);

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_fields", 32'(cur_out()), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_posit  = dir_in[i];
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("lat_s1", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         chk("lat_s2", 32'(out_valid), 32'd1);
         chk($sformatf("dir_%02h", dir_in[i]), 32'(cur_out()), 32'(dir_exp[i]));
         out_ready = 1'b1;
         @(posedge clk); #1;
      end

      n0 = n_out;
      stream(10, 0, 0, full);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("b2b_count", 32'(n_out - n0), 32'd10);
      chk("b2b_empty", 32'(exp_q.size()), 32'd0);
      chk("b2b_idle", 32'(out_valid), 32'd0);

      n0 = n_out;
      stream(10, 2, 4, full);
      chk("stall_full", 32'(full), 32'd1);
      drain("stall_drain");
      chk("stall_count", 32'(n_out - n0), 32'd10);

      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_posit  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain("rand_drain");

      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int c = 0; c < 10 && in_ready; c++) begin
         in_posit = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_posit  = 8'h5A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_s1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("post_rst_s2", 32'(out_valid), 32'd1);
      chk("post_rst_5a", 32'(cur_out()), 32'(dir_exp[1]));
      drain("final_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
